// File: rtl/sram_arb_pkg.sv
// Shared FSM encoding, port indices and phase constants for the SRAM arbiter.
package sram_arb_pkg;
    typedef enum logic [2:0] {
        ST_IDLE, ST_LO_SET, ST_LO_STB, ST_HI_SET, ST_HI_STB, ST_ACK
    } state_t;

    localparam int PORT_IF  = 0;
    localparam int PORT_LSU = 1;
    localparam int SET_CYC  = 1;
endpackage

// File: rtl/sram_rr_arb.sv
// Two-way round-robin grant select with a last-grant register.
module sram_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       take,
    output logic       gnt
);
    logic last;

    // last resets to 0 so port 1 wins the first tie after reset
    assign gnt = (req == 2'b11) ? ~last : req[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       last <= 1'b0;
        else if (take) last <= gnt;
    end
endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter onto a 16-bit async SRAM; each 32-bit access is split into low/high halves.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int STROBE_CYC = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [1:0]  i_req,
    input  logic [1:0]  i_wren,
    input  logic [31:0] i_addr0,
    input  logic [31:0] i_addr1,
    input  logic [31:0] i_wdata0,
    input  logic [31:0] i_wdata1,
    input  logic [3:0]  i_bmask0,
    input  logic [3:0]  i_bmask1,
    output logic [31:0] o_rdata0,
    output logic [31:0] o_rdata1,
    output logic [1:0]  o_ack,
    output logic [17:0] SRAM_ADDR,
    inout  wire  [15:0] SRAM_DQ,
    output logic        SRAM_CE_N,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_UB_N
);
    state_t      state, nxt;
    logic [1:0]  cnt;
    logic        phase_done, grant, sel, busy, hi, stb;
    logic        port, wren;
    logic [16:0] addr;
    logic [31:0] wdata;
    logic [3:0]  bmask;
    logic        cur_wren;
    logic [16:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [3:0]  cur_bmask;
    logic        dq_oe;
    logic [15:0] dq_out, lo_rd;
    logic        unused;

    // Byte-offset bits and anything above the 512 KiB window are dropped
    assign unused = ^{i_addr0[31:19], i_addr0[1:0], i_addr1[31:19], i_addr1[1:0]};

    assign grant   = (state == ST_IDLE) && (|i_req);
    assign SRAM_DQ = dq_oe ? dq_out : 16'bz;

    sram_rr_arb u_rr (
        .clk  (i_clk),
        .rst  (i_rst),
        .req  (i_req),
        .take (grant),
        .gnt  (sel)
    );

    always_comb begin
        if (state == ST_LO_SET || state == ST_HI_SET) phase_done = (cnt == 2'(SET_CYC - 1));
        else                                          phase_done = (cnt == 2'(STROBE_CYC - 1));
        nxt = state;
        unique case (state)
            ST_IDLE:   if (|i_req)     nxt = ST_LO_SET;
            ST_LO_SET: if (phase_done) nxt = ST_LO_STB;
            ST_LO_STB: if (phase_done) nxt = ST_HI_SET;
            ST_HI_SET: if (phase_done) nxt = ST_HI_STB;
            ST_HI_STB: if (phase_done) nxt = ST_ACK;
            default:                   nxt = ST_IDLE;
        endcase
        // Strobes are registered from the next state, so the granted request is used straight from the inputs
        if (grant) begin
            cur_wren  = i_wren[sel];
            cur_addr  = sel ? i_addr1[18:2] : i_addr0[18:2];
            cur_wdata = sel ? i_wdata1 : i_wdata0;
            cur_bmask = sel ? i_bmask1 : i_bmask0;
        end else begin
            cur_wren  = wren;
            cur_addr  = addr;
            cur_wdata = wdata;
            cur_bmask = bmask;
        end
        busy = nxt inside {ST_LO_SET, ST_LO_STB, ST_HI_SET, ST_HI_STB};
        hi   = (nxt == ST_HI_SET) || (nxt == ST_HI_STB);
        stb  = (nxt == ST_LO_STB) || (nxt == ST_HI_STB);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            port      <= 1'b0;
            wren      <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            bmask     <= '0;
            SRAM_ADDR <= '0;
            SRAM_CE_N <= 1'b1;
            SRAM_WE_N <= 1'b1;
            SRAM_OE_N <= 1'b1;
            SRAM_LB_N <= 1'b1;
            SRAM_UB_N <= 1'b1;
            dq_oe     <= 1'b0;
            dq_out    <= '0;
            lo_rd     <= '0;
            o_ack     <= '0;
            o_rdata0  <= '0;
            o_rdata1  <= '0;
        end else begin
            state <= nxt;
            cnt   <= (nxt != state) ? 2'd0 : cnt + 2'd1;
            if (grant) begin
                port  <= sel;
                wren  <= cur_wren;
                addr  <= cur_addr;
                wdata <= cur_wdata;
                bmask <= cur_bmask;
            end
            if (busy) SRAM_ADDR <= {cur_addr, hi};
            SRAM_CE_N <= ~busy;
            SRAM_OE_N <= ~(busy & ~cur_wren);
            SRAM_WE_N <= ~(stb & cur_wren);
            SRAM_LB_N <= ~busy | (cur_wren & ~(hi ? cur_bmask[2] : cur_bmask[0]));
            SRAM_UB_N <= ~busy | (cur_wren & ~(hi ? cur_bmask[3] : cur_bmask[1]));
            dq_oe     <= busy & cur_wren;
            dq_out    <= hi ? cur_wdata[31:16] : cur_wdata[15:0];
            o_ack     <= 2'b00;
            if (nxt == ST_ACK) o_ack[port] <= 1'b1;
            if (phase_done && !wren) begin
                if (state == ST_LO_STB) lo_rd <= SRAM_DQ;
                if (state == ST_HI_STB) begin
                    if (port == 1'(PORT_LSU)) o_rdata1 <= {SRAM_DQ, lo_rd};
                    else                      o_rdata0 <= {SRAM_DQ, lo_rd};
                end
            end
        end
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized scoreboard bench for sram_arbiter with a word-level memory model and an SRAM chip model.
module tb_sram_arbiter;
    localparam int S  = 1;
    localparam int L  = 4 + 2 * S;
    localparam int S3 = 3;

    logic        clk = 0, rst, rst3;
    logic [1:0]  req, wren, req3, wren3;
    logic [31:0] a_in [2], d_in [2];
    logic [3:0]  m_in [2];
    logic [31:0] rdata0, rdata1, a3, d3, rd3_0, rd3_1;
    logic [1:0]  ack, ack3;
    logic [17:0] sa, sa3;
    wire  [15:0] dq, dq3;
    logic        ce_n, we_n, oe_n, lb_n, ub_n;
    logic        ce3_n, we3_n, oe3_n, lb3_n, ub3_n;
    int          cyc = 0, n_chk = 0, n_fail = 0;

    logic [15:0] sram  [0:262143];
    logic [15:0] sram3 [0:262143];

    typedef struct {
        logic [1:0]  ack;
        logic [31:0] rd0, rd1;
        int          cyc;
    } exp_t;
    exp_t        exp_q [$];
    exp_t        mon_e;
    logic [31:0] mdl [int];
    logic [31:0] mrd [2];
    int          mlast;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_arbiter #(.STROBE_CYC(S)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_wren(wren),
        .i_addr0(a_in[0]), .i_addr1(a_in[1]), .i_wdata0(d_in[0]), .i_wdata1(d_in[1]),
        .i_bmask0(m_in[0]), .i_bmask1(m_in[1]), .o_rdata0(rdata0), .o_rdata1(rdata1),
        .o_ack(ack), .SRAM_ADDR(sa), .SRAM_DQ(dq), .SRAM_CE_N(ce_n), .SRAM_WE_N(we_n),
        .SRAM_OE_N(oe_n), .SRAM_LB_N(lb_n), .SRAM_UB_N(ub_n)
    );

    sram_arbiter #(.STROBE_CYC(S3)) dut3 (
        .i_clk(clk), .i_rst(rst3), .i_req(req3), .i_wren(wren3),
        .i_addr0(a3), .i_addr1(32'h0), .i_wdata0(d3), .i_wdata1(32'h0),
        .i_bmask0(4'hF), .i_bmask1(4'h0), .o_rdata0(rd3_0), .o_rdata1(rd3_1),
        .o_ack(ack3), .SRAM_ADDR(sa3), .SRAM_DQ(dq3), .SRAM_CE_N(ce3_n), .SRAM_WE_N(we3_n),
        .SRAM_OE_N(oe3_n), .SRAM_LB_N(lb3_n), .SRAM_UB_N(ub3_n)
    );

    // Async SRAM chips: drive on read, capture byte lanes on each clock while WE_N is low
    assign dq  = (!ce_n && !oe_n && we_n) ? sram[sa] : 16'bz;
    assign dq3 = (!ce3_n && !oe3_n && we3_n) ? sram3[sa3] : 16'bz;
    always @(posedge clk) begin
        if (!ce_n && !we_n) begin
            if (!lb_n) sram[sa][7:0]  <= dq[7:0];
            if (!ub_n) sram[sa][15:8] <= dq[15:8];
        end
        if (!ce3_n && !we3_n) begin
            if (!lb3_n) sram3[sa3][7:0]  <= dq3[7:0];
            if (!ub3_n) sram3[sa3][15:8] <= dq3[15:8];
        end
    end

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mget(int k);
        return mdl.exists(k) ? mdl[k] : 32'h0;
    endfunction

    // Reference: word-addressed memory, byte-masked writes, per-port held read data
    task automatic model_op(int p, bit w, logic [31:0] a, logic [31:0] d, logic [3:0] m, int ack_cyc);
        int k;
        logic [31:0] v;
        exp_t e;
        k = int'(a[18:2]);
        v = mget(k);
        if (w) begin
            for (int b = 0; b < 4; b++) if (m[b]) v[8*b +: 8] = d[8*b +: 8];
            mdl[k] = v;
        end else mrd[p] = v;
        mlast = p;
        e.ack = 2'(1 << p);
        e.rd0 = mrd[0];
        e.rd1 = mrd[1];
        e.cyc = ack_cyc;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("we_oe_exclusive", {we_n | oe_n, we3_n | oe3_n}, 2'b11);
            if (ack != 2'b00) begin
                if (exp_q.size() == 0) check("ack_unexpected", ack, 2'b00);
                else begin
                    mon_e = exp_q.pop_front();
                    check("ack_port", ack, mon_e.ack);
                    check("ack_cycle", cyc, mon_e.cyc);
                    check("rdata0", rdata0, mon_e.rd0);
                    check("rdata1", rdata1, mon_e.rd1);
                end
            end
        end
    end

    task automatic wait_cyc(int x);
        while (cyc < x) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_port(int p, bit w, logic [31:0] a, logic [31:0] d, logic [3:0] m);
        wren[p] = w;
        a_in[p] = a;
        d_in[p] = d;
        m_in[p] = m;
    endtask

    task automatic scramble(int p);
        set_port(p, 1'($urandom), $urandom, $urandom, 4'($urandom));
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom;
        a[18:2] = 17'($urandom_range(0, 15));
        return a;
    endfunction

    task automatic serve(int p, int g);
        wait_cyc(g + 1);
        if ($urandom_range(0, 1) == 1) begin
            req[p] = 1'b0;
            scramble(p);
        end
        wait_cyc(g + L - 1);
        req[p] = 1'b0;
        scramble(p);
    endtask

    task automatic rand_round(bit both);
        logic [1:0] who;
        int n, first, second;
        who = both ? 2'b11 : 2'($urandom_range(1, 3));
        for (int p = 0; p < 2; p++) set_port(p, 1'($urandom), rand_addr(), $urandom, 4'($urandom));
        n = cyc;
        req = who;
        first  = (who == 2'b11) ? 1 - mlast : (who[1] ? 1 : 0);
        second = 1 - first;
        model_op(first, wren[first], a_in[first], d_in[first], m_in[first], n + L - 1);
        if (who == 2'b11) model_op(second, wren[second], a_in[second], d_in[second], m_in[second], n + 2 * L - 1);
        serve(first, n);
        if (who == 2'b11) serve(second, n + L);
        wait_cyc(cyc + $urandom_range(1, 3));
    endtask

    task automatic single(int p, bit w, logic [31:0] a, logic [31:0] d, logic [3:0] m);
        int n;
        n = cyc;
        set_port(p, w, a, d, m);
        req[p] = 1'b1;
        model_op(p, w, a, d, m, n + L - 1);
        wait_cyc(n + 2);
        @(negedge clk);
        check("lo_stb_strobes", {ce_n, we_n, oe_n, lb_n, ub_n}, w ? {3'b001, ~m[0], ~m[1]} : 5'b01000);
        wait_cyc(n + 3 + S);
        @(negedge clk);
        check("hi_stb_strobes", {ce_n, we_n, oe_n, lb_n, ub_n}, w ? {3'b001, ~m[2], ~m[3]} : 5'b01000);
        wait_cyc(n + L - 1);
        req[p] = 1'b0;
        wait_cyc(cyc + 1);
    endtask

    task automatic tie_test();
        int n;
        set_port(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        set_port(0, 1'b0, 32'h10, 32'h0, 4'hF);
        n = cyc;
        req = 2'b11;
        for (int t = 0; t < 4; t++) begin
            if (t % 2 == 0) model_op(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, n + (t + 1) * L - 1);
            else            model_op(0, 1'b0, 32'h10, 32'h0, 4'hF, n + (t + 1) * L - 1);
        end
        wait_cyc(n + 1);     @(negedge clk); check("addr_wr_lo", sa, 18'h008);
        wait_cyc(n + 2 + S); @(negedge clk); check("addr_wr_hi", sa, 18'h009);
        wait_cyc(n + L + 1); @(negedge clk); check("addr_rd_lo", sa, 18'h008);
        wait_cyc(n + L + 2 + S); @(negedge clk); check("addr_rd_hi", sa, 18'h009);
        wait_cyc(n + 4 * L - 1);
        req = 2'b00;
        wait_cyc(cyc + 1);
    endtask

    task automatic reset_test();
        int n;
        n = cyc;
        set_port(0, 1'b1, 32'h0000_0FC0, 32'h12345678, 4'hF);
        req[0] = 1'b1;
        wait_cyc(n + 3 + S);
        rst = 1'b1;
        #1;
        check("rst_mid_strobes", {ce_n, we_n, oe_n, lb_n, ub_n}, 5'h1F);
        check("rst_mid_ack", ack, 2'b00);
        check("rst_mid_addr", sa, 18'h0);
        check("rst_mid_rdata", {rdata0, rdata1}, 64'h0);
        req = 2'b00;
        mlast = 0;
        mrd[0] = '0;
        mrd[1] = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic dut3_test();
        int n, got;
        for (int t = 0; t < 2; t++) begin
            n = cyc;
            wren3 = (t == 0) ? 2'b01 : 2'b00;
            a3 = 32'h40;
            d3 = 32'hCAFEF00D;
            req3 = 2'b01;
            got = -1;
            for (int k = 0; k < 20 && got < 0; k++) begin
                @(negedge clk);
                if (ack3 != 2'b00) begin
                    got = cyc;
                    check("dut3_ack_port", ack3, 2'b01);
                end
            end
            req3 = 2'b00;
            check("dut3_latency", got - n + 1, 4 + 2 * S3);
            if (t == 1) check("dut3_rdata", rd3_0, 32'hCAFEF00D);
            @(posedge clk); #1;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        for (int i = 0; i < 262144; i++) begin
            sram[i]  = '0;
            sram3[i] = '0;
        end
        rst = 1'b1;
        rst3 = 1'b1;
        req = 2'b00;
        req3 = 2'b00;
        wren3 = 2'b00;
        a3 = '0;
        d3 = '0;
        for (int p = 0; p < 2; p++) set_port(p, 1'b0, 32'h0, 32'h0, 4'h0);
        mrd[0] = '0;
        mrd[1] = '0;
        mlast = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_strobes", {ce_n, we_n, oe_n, lb_n, ub_n}, 5'h1F);
        check("rst_ack", ack, 2'b00);
        check("rst_addr", sa, 18'h0);
        check("rst_rdata", {rdata0, rdata1}, 64'h0);
        rst = 1'b0;
        rst3 = 1'b0;
        @(posedge clk);
        #1;

        tie_test();
        single(0, 1'b1, 32'h20, 32'h11223344, 4'hF);
        single(1, 1'b1, 32'hF000_0022, 32'hAABBCCDD, 4'b0101);
        single(0, 1'b0, 32'h0000_0021, 32'h0, 4'h0);
        check("mask_merge", rdata0, 32'h11BB33DD);
        single(1, 1'b1, 32'h24, 32'h55667788, 4'b1100);
        single(1, 1'b0, 32'h24, 32'h0, 4'h0);
        check("empty_half_mask", rdata1, 32'h55660000);

        repeat (40) rand_round(1'b0);
        reset_test();
        single(0, 1'b0, 32'h20, 32'h0, 4'h0);
        rand_round(1'b1);
        repeat (20) rand_round(1'b0);

        dut3_test();
        wait_cyc(cyc + 5);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 The block SHALL have parameter STROBE_CYC, default 1: strobe-phase length in cycles per 16-bit half (range 1..4).
REQ-002 The block SHALL have port i_clk  in  1  system clock; all state changes on the rising edge.
REQ-003 The block SHALL have port i_rst  in  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port i_req[1:0]  in  2  per-port access request; port 0 = instruction fetch, port 1 = LSU.
REQ-005 The block SHALL have port i_wren[1:0]  in  2  per-port write (1) or read (0).
REQ-006 The block SHALL have ports i_addr0, i_addr1  in  32  byte addresses; bits [1:0] are ignored.
REQ-007 The block SHALL have ports i_wdata0, i_wdata1  in  32  store data.
REQ-008 The block SHALL have ports i_bmask0, i_bmask1  in  4  byte enables; bit n covers byte n.
REQ-009 The block SHALL have ports o_rdata0, o_rdata1  out  32  load data, valid in the cycle o_ack of that port is high.
REQ-010 The block SHALL have port o_ack[1:0]  out  2  one-cycle completion pulse per port.
REQ-011 The block SHALL have port SRAM_ADDR  out  18  halfword address.
REQ-012 The block SHALL have port SRAM_DQ  inout  16  data bus, driven only during the write phases of REQ-018.
REQ-013 The block SHALL have ports SRAM_CE_N, SRAM_WE_N, SRAM_OE_N, SRAM_LB_N, SRAM_UB_N  out  1 each  active-low SRAM strobes, all registered.

Function
REQ-014 The block SHALL implement the FSM IDLE -> LO_SET -> LO_STB -> HI_SET -> HI_STB -> ACK -> IDLE.
REQ-015 In IDLE with any i_req bit high, the block SHALL grant one port and latch that port's wren, addr, wdata and bmask; later changes to those inputs SHALL be ignored until ACK.
REQ-016 Arbitration SHALL be round-robin: a single requester is always granted; when both request, the port not granted last wins; after reset, port 1 wins the first tie.
REQ-017 SRAM_ADDR SHALL be {addr[18:2], 0} in LO_SET/LO_STB and {addr[18:2], 1} in HI_SET/HI_STB.
REQ-018 Each xx_SET state SHALL last 1 cycle and each xx_STB state STROBE_CYC cycles, with CE_N=0 throughout both.
REQ-019 During reads, OE_N SHALL be 0 and LB_N=UB_N=0 in both SET and STB states.
REQ-020 During writes, WE_N SHALL be 0 only in STB states, the bus SHALL be driven in SET and STB states, LB_N/UB_N SHALL be the inverted bmask bits [0]/[1] (low half) or [2]/[3] (high half), and OE_N SHALL be 1.
REQ-021 Reads SHALL sample SRAM_DQ on the last STB cycle: the low half into rdata[15:0], the high half into rdata[31:16].
REQ-022 A write with both mask bits of a half equal to 0 SHALL still execute that half's states, with LB_N=UB_N=1.
REQ-023 In ACK, the block SHALL pulse o_ack for the granted port only, with all strobes at 1 and the bus released.
REQ-024 Latency SHALL be 4+2*STROBE_CYC cycles from the grant edge to the o_ack cycle; at the default this is 6 cycles.
REQ-025 The block SHALL return to IDLE after ACK; a request still high in IDLE SHALL be re-arbitrated, giving at least one idle cycle between transactions.
REQ-026 Dropping req during a transaction SHALL NOT abort it: the transaction SHALL complete and ack SHALL still pulse.
REQ-027 o_rdataN SHALL hold its last value until that port's next read completes; writes SHALL NOT modify o_rdataN.
REQ-028 The block SHALL never assert WE_N=0 and OE_N=0 in the same cycle.

Reset
REQ-029 While i_rst is high, the block SHALL immediately force: FSM=IDLE; all SRAM_*_N=1; SRAM_ADDR=0; SRAM_DQ=Z; o_ack=0; o_rdata0=o_rdata1=0; round-robin pointer to the post-reset tie rule of REQ-016.
REQ-030 A reset mid-transaction SHALL abandon the transaction with no ack; a partially written word is acceptable.

Structure
REQ-031 Package sram_arb_pkg SHALL hold the FSM state enum, the port indices (PORT_IF=0, PORT_LSU=1) and the SET length constant.
REQ-032 Round-robin grant selection SHALL be a sub-module, sram_rr_arb (2-way, with last-grant register).
REQ-033 Tristate control SHALL be a single registered drive-enable inside sram_arbiter.

Verification
REQ-034 Port 1 writes 0xDEADBEEF to addr 0x10 with bmask 0xF, then port 0 reads addr 0x10 -> SRAM_ADDR 0x008 then 0x009; o_rdata0=0xDEADBEEF; each ack arrives 6 cycles after grant.
REQ-035 Both ports request in the same cycle right after reset, held for 4 transactions -> grants in the order 1,0,1,0; exactly one o_ack bit per transaction.
REQ-036 Write 0x11223344, then write 0xAABBCCDD with bmask 0b0101, then read -> 0x11BB33DD; the second write shows LB_N=0/UB_N=1 on both halves.
REQ-037 Assert i_rst during HI_STB of a write -> all strobes at 1 and bus at Z in the same cycle; no ack; the next request starts from IDLE.
REQ-038 STROBE_CYC=3, single read -> ack at 10 cycles after grant, and the WE_N/OE_N mutual-exclusion assertion holds throughout.
